// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds renamed ALU ops until both operands are
// valid, snoops the FU wakeup broadcast, and issues the lowest-index ready
// op into the FU each cycle the FU is available.
module alu_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [3:0]                   dispatch_ALUControl,
  input  logic                         dispatch_ALUSrc,
  input  logic [31:0]                  dispatch_imm,
  input  logic                         dispatch_rs1_ready,
  input  logic [TAG_WIDTH-1:0]         dispatch_rs1_tag,
  input  logic [31:0]                  dispatch_rs1_value,
  input  logic                         dispatch_rs2_ready,
  input  logic [TAG_WIDTH-1:0]         dispatch_rs2_tag,
  input  logic [31:0]                  dispatch_rs2_value,
  input  logic [TAG_WIDTH-1:0]         dispatch_tag_to_output,
  input  logic [TAG_WIDTH-1:0]         dispatch_rob_index,
  input  logic                         wakeup_active,
  input  logic [TAG_WIDTH-1:0]         wakeup_tag,
  input  logic [31:0]                  wakeup_value,
  input  logic                         fu_is_available,
  output logic                         issue_write_enable,
  output logic [3:0]                   issue_ALUControl,
  output logic                         issue_ALUSrc,
  output logic [31:0]                  issue_imm,
  output logic [31:0]                  issue_rs1_value,
  output logic [31:0]                  issue_rs2_value,
  output logic [TAG_WIDTH-1:0]         issue_tag_to_output,
  output logic [TAG_WIDTH-1:0]         issue_rob_index,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic [3:0]           alu_ctl;
    logic                 alu_src;
    logic [31:0]          imm;
    logic                 rs1_rdy;
    logic [TAG_WIDTH-1:0] rs1_tag;
    logic [31:0]          rs1_val;
    logic                 rs2_rdy;
    logic [TAG_WIDTH-1:0] rs2_tag;
    logic [31:0]          rs2_val;
    logic [TAG_WIDTH-1:0] dst_tag;
    logic [TAG_WIDTH-1:0] rob_idx;
  } entry_t;

  entry_t [DEPTH-1:0] q;
  entry_t             new_e;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               cand_found;
  logic               dispatch_fire;

  // Full check uses registered occupancy only; an issue this cycle frees nothing yet.
  assign dispatch_ready = (occupancy != OCC_W'(DEPTH));
  assign dispatch_fire  = dispatch_valid && dispatch_ready;

  // Lowest-index free slot and lowest-index issuable entry.
  always_comb begin
    free_idx   = '0;
    sel_idx    = '0;
    cand_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!q[i].valid) free_idx = IDX_W'(i);
      if (q[i].valid && q[i].rs1_rdy && q[i].rs2_rdy) begin
        sel_idx    = IDX_W'(i);
        cand_found = 1'b1;
      end
    end
  end

  // Build the incoming entry, forwarding a same-cycle wakeup into unready sources.
  always_comb begin
    new_e         = '0;
    new_e.valid   = 1'b1;
    new_e.alu_ctl = dispatch_ALUControl;
    new_e.alu_src = dispatch_ALUSrc;
    new_e.imm     = dispatch_imm;
    new_e.rs1_rdy = dispatch_rs1_ready;
    new_e.rs1_tag = dispatch_rs1_tag;
    new_e.rs1_val = dispatch_rs1_value;
    new_e.rs2_rdy = dispatch_rs2_ready;
    new_e.rs2_tag = dispatch_rs2_tag;
    new_e.rs2_val = dispatch_rs2_value;
    new_e.dst_tag = dispatch_tag_to_output;
    new_e.rob_idx = dispatch_rob_index;
    if (!dispatch_rs1_ready && wakeup_active && (wakeup_tag == dispatch_rs1_tag)) begin
      new_e.rs1_rdy = 1'b1;
      new_e.rs1_val = wakeup_value;
    end
    if (dispatch_ALUSrc) begin
      new_e.rs2_rdy = 1'b1;
    end else if (!dispatch_rs2_ready && wakeup_active && (wakeup_tag == dispatch_rs2_tag)) begin
      new_e.rs2_rdy = 1'b1;
      new_e.rs2_val = wakeup_value;
    end
  end

  assign issue_write_enable = fu_is_available && cand_found && !flush;

  // Issue payload comes straight from the selected entry; zero when idle.
  always_comb begin
    issue_ALUControl    = '0;
    issue_ALUSrc        = 1'b0;
    issue_imm           = '0;
    issue_rs1_value     = '0;
    issue_rs2_value     = '0;
    issue_tag_to_output = '0;
    issue_rob_index     = '0;
    if (issue_write_enable) begin
      issue_ALUControl    = q[sel_idx].alu_ctl;
      issue_ALUSrc        = q[sel_idx].alu_src;
      issue_imm           = q[sel_idx].imm;
      issue_rs1_value     = q[sel_idx].rs1_val;
      issue_rs2_value     = q[sel_idx].rs2_val;
      issue_tag_to_output = q[sel_idx].dst_tag;
      issue_rob_index     = q[sel_idx].rob_idx;
    end
  end

  // Entry storage: flush beats everything; otherwise snoop, retire issued, then accept dispatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && wakeup_active) begin
          if (!q[i].rs1_rdy && (q[i].rs1_tag == wakeup_tag)) begin
            q[i].rs1_rdy <= 1'b1;
            q[i].rs1_val <= wakeup_value;
          end
          if (!q[i].rs2_rdy && (q[i].rs2_tag == wakeup_tag)) begin
            q[i].rs2_rdy <= 1'b1;
            q[i].rs2_val <= wakeup_value;
          end
        end
        if (issue_write_enable && (sel_idx == IDX_W'(i))) q[i].valid <= 1'b0;
        if (dispatch_fire && (free_idx == IDX_W'(i))) q[i] <= new_e;
      end
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({dispatch_fire, issue_write_enable})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with hand-computed expectations.
module tb_alu_issue_queue;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned TAG_WIDTH = 6;
  localparam int unsigned OCC_W     = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic [3:0]           dispatch_ALUControl;
  logic                 dispatch_ALUSrc;
  logic [31:0]          dispatch_imm;
  logic                 dispatch_rs1_ready;
  logic [TAG_WIDTH-1:0] dispatch_rs1_tag;
  logic [31:0]          dispatch_rs1_value;
  logic                 dispatch_rs2_ready;
  logic [TAG_WIDTH-1:0] dispatch_rs2_tag;
  logic [31:0]          dispatch_rs2_value;
  logic [TAG_WIDTH-1:0] dispatch_tag_to_output;
  logic [TAG_WIDTH-1:0] dispatch_rob_index;
  logic                 wakeup_active;
  logic [TAG_WIDTH-1:0] wakeup_tag;
  logic [31:0]          wakeup_value;
  logic                 fu_is_available;
  logic                 issue_write_enable;
  logic [3:0]           issue_ALUControl;
  logic                 issue_ALUSrc;
  logic [31:0]          issue_imm;
  logic [31:0]          issue_rs1_value;
  logic [31:0]          issue_rs2_value;
  logic [TAG_WIDTH-1:0] issue_tag_to_output;
  logic [TAG_WIDTH-1:0] issue_rob_index;
  logic [OCC_W-1:0]     occupancy;

  int tests_run;
  int tests_failed;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .flush                  (flush),
    .dispatch_valid         (dispatch_valid),
    .dispatch_ready         (dispatch_ready),
    .dispatch_ALUControl    (dispatch_ALUControl),
    .dispatch_ALUSrc        (dispatch_ALUSrc),
    .dispatch_imm           (dispatch_imm),
    .dispatch_rs1_ready     (dispatch_rs1_ready),
    .dispatch_rs1_tag       (dispatch_rs1_tag),
    .dispatch_rs1_value     (dispatch_rs1_value),
    .dispatch_rs2_ready     (dispatch_rs2_ready),
    .dispatch_rs2_tag       (dispatch_rs2_tag),
    .dispatch_rs2_value     (dispatch_rs2_value),
    .dispatch_tag_to_output (dispatch_tag_to_output),
    .dispatch_rob_index     (dispatch_rob_index),
    .wakeup_active          (wakeup_active),
    .wakeup_tag             (wakeup_tag),
    .wakeup_value           (wakeup_value),
    .fu_is_available        (fu_is_available),
    .issue_write_enable     (issue_write_enable),
    .issue_ALUControl       (issue_ALUControl),
    .issue_ALUSrc           (issue_ALUSrc),
    .issue_imm              (issue_imm),
    .issue_rs1_value        (issue_rs1_value),
    .issue_rs2_value        (issue_rs2_value),
    .issue_tag_to_output    (issue_tag_to_output),
    .issue_rob_index        (issue_rob_index),
    .occupancy              (occupancy)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound for the whole run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and checks happen away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_dispatch();
    dispatch_valid         = 1'b0;
    dispatch_ALUControl    = '0;
    dispatch_ALUSrc        = 1'b0;
    dispatch_imm           = '0;
    dispatch_rs1_ready     = 1'b0;
    dispatch_rs1_tag       = '0;
    dispatch_rs1_value     = '0;
    dispatch_rs2_ready     = 1'b0;
    dispatch_rs2_tag       = '0;
    dispatch_rs2_value     = '0;
    dispatch_tag_to_output = '0;
    dispatch_rob_index     = '0;
  endtask

  task automatic put_ready(input logic [3:0] ctl, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [TAG_WIDTH-1:0] dst);
    dispatch_valid         = 1'b1;
    dispatch_ALUControl    = ctl;
    dispatch_ALUSrc        = 1'b0;
    dispatch_imm           = '0;
    dispatch_rs1_ready     = 1'b1;
    dispatch_rs1_tag       = '0;
    dispatch_rs1_value     = v1;
    dispatch_rs2_ready     = 1'b1;
    dispatch_rs2_tag       = '0;
    dispatch_rs2_value     = v2;
    dispatch_tag_to_output = dst;
    dispatch_rob_index     = dst + TAG_WIDTH'(1);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    flush           = 1'b0;
    wakeup_active   = 1'b0;
    wakeup_tag      = '0;
    wakeup_value    = '0;
    fu_is_available = 1'b0;
    idle_dispatch();
    #2;
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_dready", 32'(dispatch_ready), 1);
    chk("rst_we", 32'(issue_write_enable), 0);
    chk("rst_rs1", issue_rs1_value, 0);
    tick();
    reset = 1'b0;
    tick();

    // Ready ADD issues the cycle after dispatch.
    fu_is_available = 1'b1;
    put_ready(4'd2, 32'd5, 32'd7, 6'd3);
    tick();
    idle_dispatch();
    settle();
    chk("add_we", 32'(issue_write_enable), 1);
    chk("add_ctl", 32'(issue_ALUControl), 2);
    chk("add_rs1", issue_rs1_value, 5);
    chk("add_rs2", issue_rs2_value, 7);
    chk("add_dst", 32'(issue_tag_to_output), 3);
    chk("add_rob", 32'(issue_rob_index), 4);
    chk("add_occ1", 32'(occupancy), 1);
    tick();
    chk("add_occ0", 32'(occupancy), 0);
    chk("add_we_off", 32'(issue_write_enable), 0);
    chk("add_rs1_zero", issue_rs1_value, 0);

    // Wakeup snoop: no bypass, issue exactly one cycle after the wakeup edge.
    put_ready(4'd3, 32'd0, 32'd3, 6'd8);
    dispatch_rs1_ready = 1'b0;
    dispatch_rs1_tag   = 6'd12;
    tick();
    idle_dispatch();
    settle();
    chk("or_wait1", 32'(issue_write_enable), 0);
    chk("or_occ", 32'(occupancy), 1);
    tick();
    chk("or_wait2", 32'(issue_write_enable), 0);
    wakeup_active = 1'b1;
    wakeup_tag    = 6'd12;
    wakeup_value  = 32'hF0;
    settle();
    chk("or_nobypass", 32'(issue_write_enable), 0);
    tick();
    wakeup_active = 1'b0;
    wakeup_value  = 32'h0;
    settle();
    chk("or_we", 32'(issue_write_enable), 1);
    chk("or_rs1", issue_rs1_value, 32'hF0);
    chk("or_rs2", issue_rs2_value, 3);
    chk("or_ctl", 32'(issue_ALUControl), 3);
    tick();
    chk("or_occ0", 32'(occupancy), 0);

    // Dispatch-time forwarding into both sources sharing one tag.
    put_ready(4'd1, 32'd0, 32'd0, 6'd20);
    dispatch_rs1_ready = 1'b0;
    dispatch_rs1_tag   = 6'd9;
    dispatch_rs2_ready = 1'b0;
    dispatch_rs2_tag   = 6'd9;
    wakeup_active      = 1'b1;
    wakeup_tag         = 6'd9;
    wakeup_value       = 32'h55;
    tick();
    idle_dispatch();
    wakeup_active = 1'b0;
    wakeup_value  = 32'h0;
    settle();
    chk("fwd_we", 32'(issue_write_enable), 1);
    chk("fwd_rs1", issue_rs1_value, 32'h55);
    chk("fwd_rs2", issue_rs2_value, 32'h55);
    tick();

    // Fill with FU stalled, drop the ninth, then drain in index order.
    fu_is_available = 1'b0;
    for (int i = 0; i < 8; i++) begin
      put_ready(4'(i), 32'(100 + i), 32'(200 + i), 6'(i));
      tick();
    end
    idle_dispatch();
    settle();
    chk("full_dready", 32'(dispatch_ready), 0);
    chk("full_occ", 32'(occupancy), 8);
    chk("full_we", 32'(issue_write_enable), 0);
    put_ready(4'd15, 32'd999, 32'd999, 6'd63);
    tick();
    idle_dispatch();
    settle();
    chk("drop_occ", 32'(occupancy), 8);
    fu_is_available = 1'b1;
    settle();
    chk("drain_dready", 32'(dispatch_ready), 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_we_%0d", i), 32'(issue_write_enable), 1);
      chk($sformatf("drain_rs1_%0d", i), issue_rs1_value, 32'(100 + i));
      chk($sformatf("drain_dst_%0d", i), 32'(issue_tag_to_output), 32'(i));
      tick();
    end
    chk("drain_occ0", 32'(occupancy), 0);
    chk("drain_we_off", 32'(issue_write_enable), 0);

    // ALUSrc op issues without a wakeup on its rs2 tag; also dispatch + issue together.
    fu_is_available = 1'b0;
    put_ready(4'd4, 32'h20, 32'h0, 6'd10);
    dispatch_ALUSrc    = 1'b1;
    dispatch_imm       = 32'h10;
    dispatch_rs2_ready = 1'b0;
    dispatch_rs2_tag   = 6'd4;
    tick();
    put_ready(4'd5, 32'h30, 32'h40, 6'd11);
    tick();
    put_ready(4'd6, 32'h50, 32'h60, 6'd12);
    fu_is_available = 1'b1;
    settle();
    chk("imm_we", 32'(issue_write_enable), 1);
    chk("imm_src", 32'(issue_ALUSrc), 1);
    chk("imm_imm", issue_imm, 32'h10);
    chk("imm_rs1", issue_rs1_value, 32'h20);
    chk("imm_occ", 32'(occupancy), 2);
    tick();
    idle_dispatch();
    settle();
    chk("both_occ", 32'(occupancy), 2);
    chk("second_rs1", issue_rs1_value, 32'h30);
    chk("second_rs2", issue_rs2_value, 32'h40);
    tick();
    chk("third_rs1", issue_rs1_value, 32'h50);
    tick();
    chk("imm_occ0", 32'(occupancy), 0);

    // Flush a half-full queue; it blocks issue and drops the same-cycle dispatch.
    fu_is_available = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_ready(4'd7, 32'(300 + i), 32'd1, 6'(30 + i));
      tick();
    end
    settle();
    chk("half_occ", 32'(occupancy), 4);
    fu_is_available = 1'b1;
    flush           = 1'b1;
    settle();
    chk("flush_we", 32'(issue_write_enable), 0);
    tick();
    flush = 1'b0;
    idle_dispatch();
    settle();
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_we_after", 32'(issue_write_enable), 0);

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    fu_is_available = 1'b0;
    put_ready(4'd8, 32'h77, 32'h88, 6'd40);
    tick();
    put_ready(4'd9, 32'h99, 32'hAA, 6'd41);
    tick();
    idle_dispatch();
    fu_is_available = 1'b1;
    settle();
    chk("pre_rst_we", 32'(issue_write_enable), 1);
    chk("pre_rst_occ", 32'(occupancy), 2);
    reset = 1'b1;
    #1;
    chk("arst_we", 32'(issue_write_enable), 0);
    chk("arst_occ", 32'(occupancy), 0);
    chk("arst_dready", 32'(dispatch_ready), 1);
    chk("arst_rs1", issue_rs1_value, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_we", 32'(issue_write_enable), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
Name: alu_issue_queue

Overview:
- Reservation station directly upstream of the ALU functional unit in the out-of-order core.
- Accepts renamed ALU ops from dispatch and holds them until both source operands are valid.
- Captures operand values by snooping the FU wakeup broadcast.
- Issues one ready op per cycle into the FU's issue interface whenever the FU reports available.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16).
- TAG_WIDTH, 6, width of physical tags and ROB indices.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; invalidates all entries.
- dispatch_valid  in  1  dispatch offers an op this cycle.
- dispatch_ready  out  1  queue can accept an op (not full).
- dispatch_ALUControl  in  4  op code.
- dispatch_ALUSrc  in  1  1 = rs1 op imm.
- dispatch_imm  in  32  immediate.
- dispatch_rs1_ready  in  1  rs1 value already valid.
- dispatch_rs1_tag  in  TAG_WIDTH  producer tag of rs1.
- dispatch_rs1_value  in  32  rs1 value, meaningful when rs1_ready.
- dispatch_rs2_ready  in  1  rs2 value already valid.
- dispatch_rs2_tag  in  TAG_WIDTH  producer tag of rs2.
- dispatch_rs2_value  in  32  rs2 value, meaningful when rs2_ready.
- dispatch_tag_to_output  in  TAG_WIDTH  destination tag.
- dispatch_rob_index  in  TAG_WIDTH  ROB slot.
- wakeup_active  in  1  FU result broadcast valid.
- wakeup_tag  in  TAG_WIDTH  broadcast tag.
- wakeup_value  in  32  broadcast value.
- fu_is_available  in  1  FU can accept an op this cycle.
- issue_write_enable  out  1  op presented to the FU this cycle.
- issue_ALUControl  out  4  issued op code.
- issue_ALUSrc  out  1  issued operand select.
- issue_imm  out  32  issued immediate.
- issue_rs1_value  out  32  issued rs1 value.
- issue_rs2_value  out  32  issued rs2 value.
- issue_tag_to_output  out  TAG_WIDTH  issued destination tag.
- issue_rob_index  out  TAG_WIDTH  issued ROB slot.
- occupancy  out  $clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Entry state: valid, op fields, and per-source {ready, tag, value}.
- Reset (async):
  - All entries invalid; occupancy=0; dispatch_ready=1.
  - issue_write_enable=0; all issue_* data outputs=0.
- dispatch_ready = (occupancy != DEPTH). It is computed from current occupancy only; a same-cycle issue does not free a slot for dispatch.
- Dispatch accepted when dispatch_valid && dispatch_ready; written at the clock edge into the lowest-index invalid entry.
- dispatch_valid while full: ignored, no state change.
- ALUSrc=1 at dispatch: rs2 is stored ready=1 regardless of dispatch_rs2_ready; its value is don't-care.
- Dispatch-time forwarding: if wakeup_active and wakeup_tag matches a not-ready source being dispatched, that source is stored ready with wakeup_value. Both sources may match the same tag.
- Wakeup snoop:
  - Each edge with wakeup_active, every valid entry's not-ready source whose tag equals wakeup_tag becomes ready and latches wakeup_value.
  - Already-ready sources are never overwritten.
- Selection (combinational):
  - Candidate = valid entry with both sources ready. The lowest-index candidate is selected.
  - Readiness is taken from registered state only; there is no same-cycle wakeup-to-issue bypass. An entry woken at edge N is first issuable in the cycle after N.
- Issue:
  - issue_write_enable = fu_is_available && candidate exists && !flush.
  - When asserted, issue_* carry the selected entry's fields (rs2 value passed through even if ALUSrc=1). The entry is invalidated at the same edge, when the FU captures it.
  - When deasserted, all issue_* data outputs = 0.
- Simultaneous dispatch and issue: both occur; occupancy unchanged. The issued entry cannot be the one being dispatched.
- flush: at the edge, all entries invalid and occupancy=0; the dispatch in that cycle is dropped. It has priority over dispatch, wakeup and issue.
- occupancy: registered, updated by +1 on dispatch, -1 on issue, 0 on flush.
- Tags are compared on full TAG_WIDTH; tag 0 is not special.

Test Plan:
- Dispatch ADD (ALUControl=2) with rs1_ready=1 val 5 and rs2_ready=1 val 7 while fu_is_available=1 -> next cycle issue_write_enable=1, rs1=5, rs2=7; following cycle occupancy=0.
- Dispatch OR with rs1 tag 12 not ready, rs2 ready=3; two cycles later wakeup_active tag 12 value 0xF0 -> issue_write_enable rises exactly one cycle after the wakeup edge, with issue_rs1_value=0xF0.
- Dispatch with rs1 tag 9 not ready in the same cycle as wakeup tag 9 value 0x55 -> entry stored ready; issued next cycle with rs1=0x55.
- Fill 8 entries with fu_is_available=0 -> dispatch_ready=0, occupancy=8, and a 9th dispatch is dropped. Raise fu_is_available -> entries 0..7 issue in index order, one per cycle.
- ALUSrc=1, imm=0x10, rs2_ready=0 tag 4, rs1 ready -> issues without any wakeup on tag 4.
- Half-full queue: pulse flush -> occupancy=0 next cycle, no issue that cycle. Then assert reset mid-operation -> outputs return to reset values immediately (asynchronously).
